// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the two-requester ROM arbiter.
// Owner tags mark which requester a ROM read in flight belongs to.
package rom_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int NUM_REQ        = 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_REQ0 = 2'd1,
    OWN_REQ1 = 2'd2
  } owner_t;

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } last_t;

endpackage

// File: rtl/rom_arb_select.sv
// Grant selection: request pair plus last winner gives a one-hot grant and the next last-winner value.
// ROM_ARB_ROUND_ROBIN_EN selects alternation on ties; otherwise requester 0 always wins ties.
module rom_arb_select
  import rom_arb_pkg::*;
(
  input  logic  req_0,
  input  logic  req_1,
  input  last_t last_winner,
  output logic  gnt_0,
  output logic  gnt_1,
  output last_t last_next
);

  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (req_0 && req_1) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
      if (last_winner == LAST0) begin
        gnt_1 = 1'b1;
      end else begin
        gnt_0 = 1'b1;
      end
`else
      gnt_0 = 1'b1;
`endif
    end else begin
      gnt_0 = req_0;
      gnt_1 = req_1;
    end
  end

  // The last-winner state is tracked in both builds, even when ties ignore it.
  always_comb begin
    last_next = last_winner;
    if (gnt_1) begin
      last_next = LAST1;
    end else if (gnt_0) begin
      last_next = LAST0;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous ROM; data returns two cycles after grant.
// Build option ROM_ARB_ROUND_ROBIN_EN (in rom_arb_select) enables round-robin tie-breaking.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ_0,
  input  logic                  REQ_1,
  input  logic [ADDR_WIDTH-1:0] ADDR_0,
  input  logic [ADDR_WIDTH-1:0] ADDR_1,
  output logic                  GNT_0,
  output logic                  GNT_1,
  output logic                  VALID_0,
  output logic                  VALID_1,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [DATA_WIDTH-1:0] ROM_DATA
);

  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  owner_t                tag1_q, tag1_d;
  owner_t                tag2_q, tag2_d;
  last_t                 last_q, last_d;
  logic                  gnt_0, gnt_1;

  // Requests are masked during reset so no grant can escape while state is cleared.
  rom_arb_select u_select (
    .req_0       (REQ_0 && !RESET),
    .req_1       (REQ_1 && !RESET),
    .last_winner (last_q),
    .gnt_0       (gnt_0),
    .gnt_1       (gnt_1),
    .last_next   (last_d)
  );

  always_comb begin
    rom_addr_d = rom_addr_q;
    tag1_d     = OWN_NONE;
    if (gnt_0) begin
      rom_addr_d = ADDR_0;
      tag1_d     = OWN_REQ0;
    end else if (gnt_1) begin
      rom_addr_d = ADDR_1;
      tag1_d     = OWN_REQ1;
    end
    tag2_d = tag1_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rom_addr_q <= '0;
      tag1_q     <= OWN_NONE;
      tag2_q     <= OWN_NONE;
      last_q     <= LAST1;
    end else begin
      rom_addr_q <= rom_addr_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag2_d;
      last_q     <= last_d;
    end
  end

  assign GNT_0    = gnt_0;
  assign GNT_1    = gnt_1;
  assign ROM_ADDR = rom_addr_q;
  assign VALID_0  = (tag2_q == OWN_REQ0);
  assign VALID_1  = (tag2_q == OWN_REQ1);
  assign RD_DATA  = ROM_DATA;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed, table-driven bench for rom_arbiter with a ROM model holding rom[i] = i ^ 8'hA5.
// Expectations follow the ROM_ARB_ROUND_ROBIN_EN setting of the build.
module tb_rom_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_0, req_1;
  logic [7:0] addr_0, addr_1;
  logic       gnt_0, gnt_1, valid_0, valid_1;
  logic [7:0] rd_data, rom_addr, rom_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       req0;
    logic       req1;
    logic [7:0] a0;
    logic [7:0] a1;
    logic       g0;
    logic       g1;
    logic       v0;
    logic       v1;
    logic [7:0] rd;
    logic [7:0] ra;
  } vec_t;

  vec_t vecs[25];

  always #5 clk = ~clk;

  // Synchronous ROM: data appears one cycle after the address.
  always @(posedge clk) rom_data <= rom_addr ^ 8'hA5;

  rom_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .REQ_0    (req_0),
    .REQ_1    (req_1),
    .ADDR_0   (addr_0),
    .ADDR_1   (addr_1),
    .GNT_0    (gnt_0),
    .GNT_1    (gnt_1),
    .VALID_0  (valid_0),
    .VALID_1  (valid_1),
    .RD_DATA  (rd_data),
    .ROM_ADDR (rom_addr),
    .ROM_DATA (rom_data)
  );

  function automatic vec_t mk(logic r0, logic r1, logic [7:0] a0, logic [7:0] a1,
                              logic g0, logic g1, logic v0, logic v1,
                              logic [7:0] rd, logic [7:0] ra);
    vec_t v;
    v.req0 = r0; v.req1 = r1; v.a0 = a0; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd; v.ra = ra;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic [7:0] a0, input logic [7:0] a1);
    req_0  = r0;
    req_1  = r1;
    addr_0 = a0;
    addr_1 = a1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Tie phase: rows 0-7 differ between the two tie-break policies.
`ifdef ROM_ARB_ROUND_ROBIN_EN
    vecs[0] = mk(1, 1, 8'h01, 8'h02, 1, 0, 0, 0, 8'h00, 8'h00);
    vecs[1] = mk(1, 1, 8'h01, 8'h02, 0, 1, 0, 0, 8'h00, 8'h01);
    vecs[2] = mk(1, 1, 8'h01, 8'h02, 1, 0, 1, 0, 8'hA4, 8'h02);
    vecs[3] = mk(1, 1, 8'h01, 8'h02, 0, 1, 0, 1, 8'hA7, 8'h01);
    vecs[4] = mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'hA4, 8'h02);
    vecs[5] = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'hA7, 8'h02);
    vecs[6] = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h02);
    vecs[7] = mk(1, 0, 8'h10, 8'h00, 1, 0, 0, 0, 8'h00, 8'h02);
`else
    vecs[0] = mk(1, 1, 8'h01, 8'h02, 1, 0, 0, 0, 8'h00, 8'h00);
    vecs[1] = mk(1, 1, 8'h01, 8'h02, 1, 0, 0, 0, 8'h00, 8'h01);
    vecs[2] = mk(1, 1, 8'h01, 8'h02, 1, 0, 1, 0, 8'hA4, 8'h01);
    vecs[3] = mk(1, 1, 8'h01, 8'h02, 1, 0, 1, 0, 8'hA4, 8'h01);
    vecs[4] = mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'hA4, 8'h01);
    vecs[5] = mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'hA4, 8'h01);
    vecs[6] = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h01);
    vecs[7] = mk(1, 0, 8'h10, 8'h00, 1, 0, 0, 0, 8'h00, 8'h01);
`endif
    vecs[8]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h10);
    vecs[9]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'hB5, 8'h10);
    vecs[10] = mk(0, 1, 8'h00, 8'h20, 0, 1, 0, 0, 8'h00, 8'h10);
    vecs[11] = mk(0, 1, 8'h00, 8'h21, 0, 1, 0, 0, 8'h00, 8'h20);
    vecs[12] = mk(0, 1, 8'h00, 8'h22, 0, 1, 0, 1, 8'h85, 8'h21);
    vecs[13] = mk(0, 1, 8'h00, 8'h23, 0, 1, 0, 1, 8'h84, 8'h22);
    vecs[14] = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h87, 8'h23);
    vecs[15] = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h86, 8'h23);
    vecs[16] = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h23);
    vecs[17] = mk(0, 1, 8'h00, 8'hFF, 0, 1, 0, 0, 8'h00, 8'h23);
    vecs[18] = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'hFF);
    vecs[19] = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h5A, 8'hFF);
    vecs[20] = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'hFF);
    vecs[21] = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'hFF);
    vecs[22] = mk(1, 1, 8'h40, 8'h41, 1, 0, 0, 0, 8'h00, 8'hFF);
    vecs[23] = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h40);
    vecs[24] = mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'hE5, 8'h40);

    // Reset state, with requests held high to show grants stay masked.
    rst = 1'b1;
    applyStimulus(1, 1, 8'h55, 8'h66);
    @(negedge clk);
    checkOutput("reset gnt0", gnt_0, 0);
    checkOutput("reset gnt1", gnt_1, 0);
    checkOutput("reset valid0", valid_0, 0);
    checkOutput("reset valid1", valid_1, 0);
    checkOutput("reset rom_addr", rom_addr, 8'h00);
    nextCycle();
    applyStimulus(0, 0, 8'h00, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].req0, vecs[i].req1, vecs[i].a0, vecs[i].a1);
      @(negedge clk);
      checkOutput($sformatf("row%0d gnt0", i), gnt_0, vecs[i].g0);
      checkOutput($sformatf("row%0d gnt1", i), gnt_1, vecs[i].g1);
      checkOutput($sformatf("row%0d valid0", i), valid_0, vecs[i].v0);
      checkOutput($sformatf("row%0d valid1", i), valid_1, vecs[i].v1);
      checkOutput($sformatf("row%0d rom_addr", i), rom_addr, vecs[i].ra);
      if (vecs[i].v0 || vecs[i].v1)
        checkOutput($sformatf("row%0d rd_data", i), rd_data, vecs[i].rd);
      nextCycle();
    end

    // Mid-flight reset: grant 8'h30, then reset one cycle later discards that read.
    applyStimulus(1, 0, 8'h30, 8'h00);
    @(negedge clk);
    checkOutput("rst_seq gnt0", gnt_0, 1);
    nextCycle();
    applyStimulus(0, 0, 8'h00, 8'h00);
    checkOutput("rst_seq rom_addr loaded", rom_addr, 8'h30);
    rst = 1'b1;
    applyStimulus(1, 1, 8'h31, 8'h32);
    #1;
    checkOutput("rst_seq async rom_addr", rom_addr, 8'h00);
    checkOutput("rst_seq gnt0 masked", gnt_0, 0);
    checkOutput("rst_seq gnt1 masked", gnt_1, 0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 0, 8'h00, 8'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_seq post%0d valid0", c), valid_0, 0);
      checkOutput($sformatf("rst_seq post%0d valid1", c), valid_1, 0);
      checkOutput($sformatf("rst_seq post%0d rom_addr", c), rom_addr, 8'h00);
      nextCycle();
    end
    applyStimulus(1, 1, 8'h44, 8'h45);
    @(negedge clk);
    checkOutput("rst_seq tie gnt0", gnt_0, 1);
    checkOutput("rst_seq tie gnt1", gnt_1, 0);
    nextCycle();
    applyStimulus(0, 0, 8'h00, 8'h00);
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning ROM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning ROM data width.
REQ-003 SHALL have CLK  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have REQ_0 / REQ_1  input  1  read request from requester 0 (CPU fetch) / requester 1 (auxiliary reader).
REQ-006 SHALL have ADDR_0 / ADDR_1  input  ADDR_WIDTH  read address; held stable with REQ until granted.
REQ-007 SHALL have GNT_0 / GNT_1  output  1  combinational; high in the cycle the request is accepted.
REQ-008 SHALL have VALID_0 / VALID_1  output  1  RD_DATA carries this requester's read result this cycle.
REQ-009 SHALL have RD_DATA  output  DATA_WIDTH  shared read-data return, driven from ROM_DATA.
REQ-010 SHALL have ROM_ADDR  output  ADDR_WIDTH  registered address to the single-port synchronous ROM.
REQ-011 SHALL have ROM_DATA  input  DATA_WIDTH  ROM output, registered inside ROM, one cycle after ROM_ADDR.

Function
REQ-012 SHALL accept at most one request per cycle; GNT_0 and GNT_1 never high together.
REQ-013 SHALL grant only when the corresponding REQ is high; GNT is a function of REQ_0, REQ_1 and the registered last-winner state only.
REQ-014 SHALL, at the edge ending a grant cycle T, load ROM_ADDR with the winner's ADDR and record the winner in stage-1 owner tag.
REQ-015 SHALL advance the owner tag to stage 2 at the next edge; VALID_n high in cycle T+2 for winner n; fixed latency 2 cycles from grant.
REQ-016 SHALL sustain one grant per cycle (back-to-back, including consecutive grants to the same requester).
REQ-017 SHALL hold ROM_ADDR unchanged in cycles with no grant.
REQ-018 SHALL drive RD_DATA = ROM_DATA every cycle; consumers qualify with VALID only.
REQ-019 SHALL keep last-winner state (states LAST0, LAST1); transitions LAST0->LAST1 on grant to 1, LAST1->LAST0 on grant to 0, no change without grant.
REQ-020 SHALL, single requester active, grant it immediately regardless of last-winner state.
REQ-021 SHALL never produce VALID for a request that was not granted; requester dropping REQ without GNT is legal and discarded.

Reset
REQ-022 SHALL on RESET: ROM_ADDR=0, both owner-tag stages empty, VALID_0=VALID_1=0, state LAST1 (requester 0 wins first tie).
REQ-023 SHALL hold GNT_0=GNT_1=0 while RESET is high.
REQ-024 SHALL discard in-flight reads when RESET asserts mid-operation; no VALID in the two cycles after release from reads issued before reset.

Configuration
REQ-025 SHALL with ROM_ARB_ROUND_ROBIN_EN defined resolve simultaneous REQ_0/REQ_1 to the requester that is not the last winner (alternation).
REQ-026 SHALL without ROM_ARB_ROUND_ROBIN_EN resolve simultaneous requests to requester 0 always (fixed priority); last-winner state still maintained, unused for tie-break.

Structure
REQ-027 SHALL place ADDR/DATA width defaults, requester count (2) and owner-tag encoding (NONE, REQ0, REQ1) in shared package rom_arb_pkg.
REQ-028 SHALL implement grant selection in one sub-module rom_arb_select (REQ pair + last-winner -> one-hot grant); pipeline and ROM_ADDR register in rom_arbiter.

Verification (ROM model contents rom[i] = i XOR 8'hA5)
REQ-029 SHALL check: REQ_0=1, ADDR_0=8'h10 alone -> GNT_0 same cycle, ROM_ADDR=8'h10 next cycle, VALID_0=1 and RD_DATA=8'hB5 two cycles after grant.
REQ-030 SHALL check: REQ_0 and REQ_1 held high 4 cycles, ADDR_0=8'h01, ADDR_1=8'h02 -> round-robin grants 0,1,0,1; without macro grants 0,0,0,0 and VALID_1 never high.
REQ-031 SHALL check: REQ_1 held with ADDR_1 stepping 8'h20..8'h23 each granted cycle -> four consecutive VALID_1 with RD_DATA 8'h85,8'h84,8'h87,8'h86.
REQ-032 SHALL check: RESET pulsed one cycle after grant of ADDR_0=8'h30 -> no VALID_0 afterwards, ROM_ADDR=0, next tie goes to requester 0.
REQ-033 SHALL check: ADDR_1=8'hFF granted -> RD_DATA=8'h5A with VALID_1; ROM_ADDR stays 8'hFF through 3 idle cycles.
